// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port (fetch/data) round-robin bus master arbiter.
// Optional timeout/abort: define MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        stall,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DATA
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_d;
  logic        r_is_wr;
  logic [31:0] r_address;
  logic [31:0] r_writedata;
  logic [3:0]  r_byteenable;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_if_done;
  logic        r_d_done;
  logic        w_f_elig;
  logic        w_d_elig;
  logic        w_grant_f;
  logic        w_grant_d;
  logic        w_cpl;
  logic        w_busy;

  // A requester whose done is high this cycle is not eligible again.
  assign w_f_elig = if_req & ~r_if_done;
  assign w_d_elig = (d_read | d_write) & ~r_d_done;
  assign w_busy   = (r_state == S_FETCH) | (r_state == S_DATA);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic [8:0] w_cnt_inc;
  logic       w_hit;
  logic       w_timeout;
  logic       r_bus_error;

  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_hit     = w_cnt_inc >= 9'(TIMEOUT_CYCLES);
`else
  logic w_unused_to;
  assign w_unused_to = |32'(TIMEOUT_CYCLES);
`endif

  // Next-state: grant in IDLE, complete or abort while busy.
  always_comb begin
    w_next    = r_state;
    w_grant_f = 1'b0;
    w_grant_d = 1'b0;
    w_cpl     = 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_f_elig && (!w_d_elig || r_last_d)) begin
          w_next    = S_FETCH;
          w_grant_f = 1'b1;
        end else if (w_d_elig) begin
          w_next    = S_DATA;
          w_grant_d = 1'b1;
        end
      end
      S_FETCH, S_DATA: begin
        if (!waitrequest) begin
          w_cpl  = 1'b1;
          w_next = S_IDLE;
        end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        else if (w_hit) begin
          w_timeout = 1'b1;
          w_next    = S_ERROR;
        end
`endif
      end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      S_ERROR: w_next = S_ERROR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // State register, done pulses and grant history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_last_d  <= 1'b1;
    end else if (clk_enable) begin
      r_state   <= w_next;
      r_if_done <= w_cpl & (r_state == S_FETCH);
      r_d_done  <= w_cpl & (r_state == S_DATA);
      if (w_grant_f) r_last_d <= 1'b0;
      if (w_grant_d) r_last_d <= 1'b1;
    end
  end

  // Latch the granted request so bus outputs stay stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_address    <= '0;
      r_byteenable <= '0;
      r_writedata  <= '0;
      r_is_wr      <= 1'b0;
    end else if (clk_enable) begin
      if (w_grant_f) begin
        r_address    <= if_addr;
        r_byteenable <= 4'hF;
        r_is_wr      <= 1'b0;
      end
      if (w_grant_d) begin
        r_address    <= d_addr;
        r_byteenable <= d_byteenable;
        r_is_wr      <= d_write;
        if (d_write) r_writedata <= d_wdata;
      end
    end
  end

  // Capture read data on read completion only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (clk_enable && w_cpl) begin
      if (r_state == S_FETCH) r_if_rdata <= readdata;
      if (r_state == S_DATA && !r_is_wr) r_d_rdata <= readdata;
    end
  end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  // Wait-cycle counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_bus_error <= 1'b0;
    end else if (clk_enable) begin
      if (w_grant_f || w_grant_d) r_cnt <= '0;
      else if (w_busy && waitrequest) r_cnt <= w_cnt_inc[7:0];
      if (w_timeout) r_bus_error <= 1'b1;
    end
  end
  assign bus_error = r_bus_error;
`else
  assign bus_error = 1'b0;
`endif

  assign read  = (r_state == S_FETCH)
               | ((r_state == S_DATA) & ~r_is_wr);
  assign write = (r_state == S_DATA) & r_is_wr;
  assign stall = reset & (w_busy | ~(r_state == S_IDLE)
               | w_f_elig | w_d_elig);

  assign address    = r_address;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;
  assign if_rdata   = r_if_rdata;
  assign d_rdata    = r_d_rdata;
  assign if_done    = r_if_done;
  assign d_done     = r_d_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed + random checks of mem_bus_arbiter
// against a transaction-level model of grants, data and done pulses.
module tb_mem_bus_arbiter;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        stall;
  logic        bus_error;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_if_rdata;
  logic [31:0] m_d_rdata;
  logic [31:0] m_wdata;
  bit          m_last_d;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_byteenable(d_byteenable),
    .d_rdata(d_rdata), .d_done(d_done),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .waitrequest(waitrequest),
    .stall(stall), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_if_rdata = '0;
    m_d_rdata  = '0;
    m_wdata    = '0;
    m_last_d   = 1'b1;
  endtask

  // One granted transfer: grant at the next edge, w wait cycles.
  task automatic serve(input bit is_f, input logic [31:0] a,
                       input logic [3:0] be, input bit wr,
                       input logic [31:0] wd, input int w,
                       input logic [31:0] rd, input bit other);
    if (!is_f && wr) m_wdata = wd;
    for (int i = 0; i <= w; i++) begin
      @(negedge clk);
      chk("read", read, is_f || !wr);
      chk("write", write, !is_f && wr);
      chk("address", address, a);
      chk("byteenable", byteenable, be);
      chk("writedata", writedata, m_wdata);
      chk("stall_busy", stall, 1);
      chk("done_busy", {if_done, d_done}, 0);
      waitrequest = (i < w);
      readdata = (i < w) ? $urandom : rd;
    end
    @(negedge clk);
    if (is_f) m_if_rdata = rd;
    else if (!wr) m_d_rdata = rd;
    m_last_d = !is_f;
    chk("if_done", if_done, is_f);
    chk("d_done", d_done, !is_f);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    chk("stall_done", stall, other);
    chk("bus_idle", {read, write}, 0);
    waitrequest = 1'b0;
  endtask

  // Present requests together from IDLE; model picks the order.
  task automatic txn(input bit f, input bit dr, input bit dw,
                     input logic [3:0] dbe, input int wf, input int wdc);
    logic [31:0] fa, da, dwd, rf, rdd;
    bit dq, f_first;
    fa = $urandom; da = $urandom; dwd = $urandom;
    rf = $urandom; rdd = $urandom;
    if_req = f; if_addr = fa;
    d_read = dr; d_write = dw; d_addr = da;
    d_wdata = dwd; d_byteenable = dbe;
    dq = dr | dw;
    #1 chk("stall_req", stall, 1);
    f_first = f && (!dq || m_last_d);
    if (f_first) begin
      serve(1, fa, 4'hF, 0, 0, wf, rf, dq);
      if_req = 1'b0;
      if (dq) begin
        serve(0, da, dbe, dw, dwd, wdc, rdd, 0);
        d_read = 1'b0; d_write = 1'b0;
      end
    end else begin
      serve(0, da, dbe, dw, dwd, wdc, rdd, f);
      d_read = 1'b0; d_write = 1'b0;
      if (f) begin
        serve(1, fa, 4'hF, 0, 0, wf, rf, 0);
        if_req = 1'b0;
      end
    end
    @(negedge clk);
    chk("idle_stall", stall, 0);
    chk("idle_bus", {read, write}, 0);
    chk("idle_done", {if_done, d_done}, 0);
  endtask

  initial begin
    bit f;
    int dk;
    reset = 1'b0; clk_enable = 1'b1;
    if_req = 0; if_addr = 0; d_read = 0; d_write = 0;
    d_addr = 0; d_wdata = 0; d_byteenable = 0;
    readdata = 0; waitrequest = 0;
    model_reset();
    #1;
    chk("rst_bus", {read, write, stall, bus_error}, 0);
    chk("rst_done", {if_done, d_done}, 0);
    repeat (2) @(negedge clk);
    chk("rst_addr", address, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // Minimum-latency fetch.
    if_req = 1'b1; if_addr = 32'hBFC00000;
    serve(1, 32'hBFC00000, 4'hF, 0, 0, 0, 32'h24020005, 0);
    if_req = 1'b0;
    @(negedge clk);

    // Ties after reset alternate F, D, F, D.
    repeat (4) txn(1, 1, 0, 4'hF, 0, 1);

    // Data write with three wait cycles.
    d_write = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF;
    d_byteenable = 4'b0011;
    serve(0, 32'h1000, 4'b0011, 1, 32'hDEADBEEF, 3, 32'h55AA55AA, 0);
    d_write = 1'b0;
    @(negedge clk);

    // Read and write together, and zero byte-enable.
    txn(0, 1, 1, 4'hC, 0, 2);
    txn(0, 0, 1, 4'h0, 0, 0);

    // Clock enable low holds the pending grant.
    if_req = 1'b1; if_addr = 32'h40; clk_enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ce_hold_read", read, 0);
      chk("ce_hold_stall", stall, 1);
    end
    clk_enable = 1'b1;
    serve(1, 32'h40, 4'hF, 0, 0, 1, 32'h13572468, 0);
    if_req = 1'b0;
    @(negedge clk);

    // Randomized request mixes.
    for (int n = 0; n < 40; n++) begin
      f = 1'($urandom_range(0, 1));
      dk = $urandom_range(0, 3);
      if (!f && dk == 0) f = 1'b1;
      txn(f, dk[0], dk[1], 4'($urandom), $urandom_range(0, 3),
          $urandom_range(0, 3));
    end

    // Reset in the middle of a waiting data write.
    d_write = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D;
    d_byteenable = 4'hF; waitrequest = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mid_write", write, 1);
    end
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_write", write, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_addr", address, 0);
    chk("mid_rst_rdata", if_rdata | d_rdata, m_if_rdata);
    @(negedge clk);
    d_write = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_done", d_done, 0);
      chk("post_rst_stall", stall, 0);
    end

    // A stuck slave: abort with timeout, or wait indefinitely.
    if_req = 1'b1; if_addr = 32'h80; waitrequest = 1'b1;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_read", read, 1);
      chk("to_err_early", bus_error, 0);
    end
    @(negedge clk);
    if_req = 1'b0;
    repeat (3) begin
      chk("to_read_off", read, 0);
      chk("to_err", bus_error, 1);
      chk("to_stall", stall, 1);
      chk("to_done", if_done, 0);
      @(negedge clk);
    end
    reset = 1'b0;
    #1 chk("to_rst_err", bus_error, 0);
    @(negedge clk);
    reset = 1'b1;
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("wait_read", read, 1);
      chk("wait_err", bus_error, 0);
      chk("wait_done", if_done, 0);
    end
    waitrequest = 1'b0; readdata = 32'h0BADF00D;
    @(negedge clk);
    if_req = 1'b0;
    chk("wait_if_done", if_done, 1);
    chk("wait_if_rdata", if_rdata, 32'h0BADF00D);
`endif
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the waitrequest cycles before abort; it is used only under REQ-031.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, with asynchronous, active-low reset.
REQ-004 The block SHALL have port clk_enable, input, 1; when low, all state, counters and registered outputs hold.
REQ-005 The block SHALL have fetch-port signals: if_req in 1; if_addr in 32; if_rdata out 32 (registered); if_done out 1 (one-cycle pulse).
REQ-006 The block SHALL have data-port signals: d_read in 1; d_write in 1; d_addr in 32; d_wdata in 32; d_byteenable in 4; d_rdata out 32 (registered); d_done out 1 (one-cycle pulse).
REQ-007 The block SHALL have bus-master signals: address out 32; read out 1; write out 1; writedata out 32; byteenable out 4; readdata in 32; waitrequest in 1.
REQ-008 The block SHALL have datapath outputs: stall out 1; bus_error out 1.

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, DATA and ERROR; ERROR is reachable only under REQ-031.
REQ-011 In IDLE, the block SHALL treat a data request as d_read|d_write and a fetch request as if_req.
REQ-012 In IDLE, a requester whose done output is high in that cycle SHALL be ignored, so a held request is not re-granted.
REQ-013 With a single eligible requester in IDLE, the block SHALL grant it: fetch goes to FETCH, data goes to DATA.
REQ-014 With both requesters eligible, the block SHALL grant the one not granted last; the last_grant register resets to DATA, so the first tie goes to FETCH.
REQ-015 On the grant edge, the block SHALL latch address, byteenable (4'hF for fetch) and writedata (data writes only).
REQ-016 In FETCH, the block SHALL drive read=1 and write=0.
REQ-017 In DATA, the block SHALL drive write=d_write and read=d_read&~d_write, so write wins when both are high.
REQ-018 In IDLE and ERROR, the block SHALL drive read=write=0.
REQ-019 A transfer SHALL complete on the edge where the state is FETCH or DATA and waitrequest=0; at that edge the block returns to IDLE and pulses the matching done for exactly the next cycle.
REQ-020 On a read completion, the block SHALL capture readdata into if_rdata or d_rdata; the other rdata register and writes SHALL leave the rdata registers unchanged.
REQ-021 Minimum latency SHALL be: request in IDLE at cycle 0, bus strobe in cycle 1 with waitrequest=0, done high and state IDLE in cycle 2.
REQ-022 Request inputs SHALL be ignored while the state is FETCH or DATA, and bus outputs SHALL remain stable until completion.
REQ-023 The block SHALL drive stall = (state!=IDLE) | eligible request present in IDLE; stall is 0 in cycles where done is high and no other request is eligible.
REQ-024 The block SHALL ignore a d_byteenable of 0, passing it to the bus unchanged.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE, deassert read/write, and clear if_done, d_done and bus_error.
REQ-026 Asserting reset SHALL immediately force stall=0, if_rdata=d_rdata=0, address=writedata=0, byteenable=0 and last_grant=DATA.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; after release the FSM starts in IDLE.

Configuration
REQ-030 Macro MEM_BUS_ARBITER_TIMEOUT_EN SHALL select the timeout feature (REQ-031 when defined, REQ-032 when undefined).
REQ-031 With MEM_BUS_ARBITER_TIMEOUT_EN defined:
- an 8-bit counter clears on grant and increments on each FETCH/DATA cycle with waitrequest=1;
- when it reaches TIMEOUT_CYCLES, the FSM enters ERROR, deasserts read/write, pulses no done, holds stall=1, and sets bus_error sticky;
- ERROR exits only by reset.
REQ-032 With MEM_BUS_ARBITER_TIMEOUT_EN undefined, the block SHALL have no counter, no ERROR state and bus_error tied to 0, and SHALL wait on waitrequest indefinitely.

Verification
REQ-040 Fetch only: if_req=1, if_addr=0xBFC00000, waitrequest=0, readdata=0x24020005 -> read=1 and address=0xBFC00000 in cycle 1; if_done=1 and if_rdata=0x24020005 in cycle 2; no re-grant in cycle 2.
REQ-041 Tie after reset: if_req=1 and d_read=1 together -> FETCH first; when if_done pulses, d_read is still held -> DATA next; repeated ties alternate F,D,F,D.
REQ-042 Data write with wait: d_write=1, d_addr=0x1000, d_wdata=0xDEADBEEF, d_byteenable=4'b0011, waitrequest=1 for 3 cycles -> bus outputs stable for 4 cycles; d_done 1 cycle after waitrequest falls; d_rdata unchanged.
REQ-043 d_read=d_write=1 -> only write asserted on the bus.
REQ-044 Reset low during DATA with waitrequest=1 -> write=0 and stall=0 immediately; no d_done after release.
REQ-045 MEM_BUS_ARBITER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, waitrequest held 1 -> bus_error=1 after 4 wait cycles; read=0, stall=1 until reset; undefined -> read held indefinitely, bus_error=0.
